// File: rtl/clint.sv
// Core-local interruptor: 64-bit machine timer with compare, plus the software-interrupt bit.
// Single-cycle bus slave; interrupt outputs are registered levels.
module clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        timer_irpt,
    output logic        soft_irpt
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [13:0] W_MSIP    = 14'h0000;
    localparam logic [13:0] W_CMP_LO  = 14'h1000;
    localparam logic [13:0] W_CMP_HI  = 14'h1001;
    localparam logic [13:0] W_TIME_LO = 14'h2FFE;
    localparam logic [13:0] W_TIME_HI = 14'h2FFF;

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          timer_q, timer_d;
    logic          soft_q, soft_d;

    logic [29:0] off_w;
    logic [13:0] word;
    logic        in_range, acc, wr_en, tick;
    logic        unused_addr_bits;

    // Word offset; bits [1:0] of the byte address carry no information.
    assign off_w            = clint_addr[31:2] - BASE_ADDR[31:2];
    assign word             = off_w[13:0];
    assign in_range         = (off_w[29:14] == 16'h0000);
    assign acc              = clint_valid && in_range;
    assign wr_en            = acc && (clint_wstrb != 4'h0) && !clint_instr;
    assign unused_addr_bits = ^clint_addr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        tick  = 1'b0;
        pre_d = pre_q + 1'b1;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            tick  = 1'b1;
        end

        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = 32'h0;

        if (acc && !wr_en) begin
            unique case (word)
                W_MSIP:    rdata_d = {31'h0, msip_q};
                W_CMP_LO:  rdata_d = mtimecmp_q[31:0];
                W_CMP_HI:  rdata_d = mtimecmp_q[63:32];
                W_TIME_LO: rdata_d = mtime_q[31:0];
                W_TIME_HI: rdata_d = mtime_q[63:32];
                default:   rdata_d = 32'h0;
            endcase
        end

        // A bus write to mtime overrides that cycle's increment.
        if (wr_en) begin
            unique case (word)
                W_MSIP:    if (clint_wstrb[0]) msip_d = clint_wdata[0];
                W_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
                W_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
                W_TIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], clint_wdata, clint_wstrb)};
                W_TIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};
                default:   ;
            endcase
        end

        ready_d = acc;
        timer_d = (mtime_q >= mtimecmp_q);
        soft_d  = msip_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            pre_q      <= '0;
            rdata_q    <= 32'h0;
            ready_q    <= 1'b0;
            timer_q    <= 1'b0;
            soft_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            pre_q      <= pre_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            timer_q    <= timer_d;
            soft_q     <= soft_d;
        end
    end

    assign clint_rdata = rdata_q;
    assign clint_ready = ready_q;
    assign timer_irpt  = timer_q;
    assign soft_irpt   = soft_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV 1 and 4) share one bus stimulus and are checked
// every cycle against a transaction-level model of the register map and timer.
module tb_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst, valid, instr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, tirq0, tirq1, sirq0, sirq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_clint_div1 (
        .clk(clk), .rst(rst), .clint_valid(valid), .clint_instr(instr), .clint_addr(addr),
        .clint_wdata(wdata), .clint_wstrb(wstrb), .clint_rdata(rdata0), .clint_ready(ready0),
        .timer_irpt(tirq0), .soft_irpt(sirq0));

    clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_clint_div4 (
        .clk(clk), .rst(rst), .clint_valid(valid), .clint_instr(instr), .clint_addr(addr),
        .clint_wdata(wdata), .clint_wstrb(wstrb), .clint_rdata(rdata1), .clint_ready(ready1),
        .timer_irpt(tirq1), .soft_irpt(sirq1));

    // Reference state per instance: [0] divides by 1, [1] divides by 4.
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    int unsigned m_cnt  [2];
    int unsigned m_div  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [31:0] put_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) & 32'hFFFF_FFFC;
        case (off)
            32'h0000: return {31'h0, m_msip[i]};
            32'h4000: return m_cmp[i][31:0];
            32'h4004: return m_cmp[i][63:32];
            32'hBFF8: return m_time[i][31:0];
            32'hBFFC: return m_time[i][63:32];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_time[i] = 64'h0;
            m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip[i] = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input bit ins);
        logic [31:0] e_rd  [2];
        bit          e_rdy [2];
        bit          e_t   [2];
        bit          e_s   [2];
        logic [63:0] nt;
        logic [31:0] off;
        bit          accepted, is_wr;
        rst = r; valid = v; addr = a; wdata = wd; wstrb = ws; instr = ins;
        off      = a - BASE;
        accepted = v && (off < 32'h0001_0000);
        is_wr    = accepted && (ws != 4'h0) && !ins;
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                e_rd[i] = 0; e_rdy[i] = 0; e_t[i] = 0; e_s[i] = 0;
            end
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_rdy[i] = accepted;
                e_rd[i]  = (accepted && !is_wr) ? model_read(i, a) : 32'h0;
                e_t[i]   = (m_time[i] >= m_cmp[i]);
                e_s[i]   = m_msip[i];
                nt = ((m_cnt[i] % m_div[i]) == m_div[i] - 1) ? m_time[i] + 64'd1 : m_time[i];
                m_cnt[i]++;
                if (is_wr) begin
                    case (off & 32'hFFFF_FFFC)
                        32'h0000: if (ws[0]) m_msip[i] = wd[0];
                        32'h4000: m_cmp[i][31:0]  = put_bytes(m_cmp[i][31:0], wd, ws);
                        32'h4004: m_cmp[i][63:32] = put_bytes(m_cmp[i][63:32], wd, ws);
                        32'hBFF8: nt = {m_time[i][63:32], put_bytes(m_time[i][31:0], wd, ws)};
                        32'hBFFC: nt = {put_bytes(m_time[i][63:32], wd, ws), m_time[i][31:0]};
                        default: ;
                    endcase
                end
                m_time[i] = nt;
            end
        end
        @(posedge clk);
        #1;
        check("ready_div1", ready0, e_rdy[0]);
        check("ready_div4", ready1, e_rdy[1]);
        check("timer_div1", tirq0, e_t[0]);
        check("timer_div4", tirq1, e_t[1]);
        check("soft_div1", sirq0, e_s[0]);
        check("soft_div4", sirq1, e_s[1]);
        if (e_rdy[0] || !r) check("rdata_div1", rdata0, e_rd[0]);
        if (e_rdy[1] || !r) check("rdata_div4", rdata1, e_rd[1]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1, 0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic rd(input logic [31:0] off);
        cycle(1, 1, BASE + off, 32'h0, 4'h0, 0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        cycle(1, 1, BASE + off, d, s, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] off;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        m_div[0] = 1;
        m_div[1] = 4;
        model_reset();
        rst = 0; valid = 0; instr = 0; addr = 0; wdata = 0; wstrb = 0;
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 0);
        cycle(0, 1, BASE + 32'hBFF8, 32'h0, 4'h0, 0);

        // Free-running timer and reset values of mtimecmp
        idle(4);  rd(32'hBFF8);
        idle(9);  rd(32'hBFF8);
        rd(32'h4000); rd(32'h4004); rd(32'h0000); rd(32'hBFFC);

        // Compare threshold crossing and clearing
        wr(32'h4000, 32'd100, 4'hF); wr(32'h4004, 32'h0, 4'hF);
        wr(32'hBFFC, 32'h0, 4'hF);   wr(32'hBFF8, 32'd90, 4'hF);
        idle(16);
        wr(32'h4000, 32'd200, 4'hF);
        idle(3);

        // Software interrupt bit
        wr(32'h0000, 32'h1, 4'hF); rd(32'h0000); idle(1);
        wr(32'h0000, 32'hFFFF_FFFE, 4'hF); rd(32'h0000); idle(1);

        // Low-to-high carry
        wr(32'hBFFC, 32'h0, 4'hF); wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        idle(1); rd(32'hBFFC); rd(32'hBFF8);
        idle(3); rd(32'hBFFC); rd(32'hBFF8);

        // Byte strobes, hole reads, out-of-range, instruction fetch
        wr(32'h4000, 32'hFFFF_FFFF, 4'hF);
        wr(32'h4000, 32'hAABB_CCDD, 4'b0010); rd(32'h4000);
        rd(32'h8000);
        cycle(1, 1, BASE + 32'h0001_0000, 32'h0, 4'h0, 0);
        cycle(1, 1, BASE - 32'h4, 32'h0, 4'h0, 0);
        cycle(1, 1, BASE + 32'h4004, 32'h1234_5678, 4'hF, 1);
        rd(32'h4004);
        wr(32'h8000, 32'hDEAD_BEEF, 4'hF); rd(32'h8000);

        // Back-to-back requests, then reset dropping an in-flight request
        rd(32'hBFF8); rd(32'hBFF8); wr(32'h0000, 32'h1, 4'h1); rd(32'h0000);
        cycle(0, 1, BASE + 32'hBFF8, 32'h0, 4'h0, 0);
        rd(32'h4000); rd(32'h4004); rd(32'h0000); rd(32'hBFF8);
        idle(7); rd(32'hBFF8);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 7))
                0: off = 32'h0000;
                1: off = 32'h4000;
                2: off = 32'h4004;
                3: off = 32'hBFF8;
                4: off = 32'hBFFC;
                5: off = {16'h0, 16'($urandom_range(0, 16'hFFFF))};
                6: off = 32'h0001_0000 + $urandom_range(0, 255);
                default: off = 32'hBFF8;
            endcase
            a = BASE + off;
            d = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            cycle(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), a, d, s,
                  ($urandom_range(0, 19) == 0));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
